sdram_image_loader: RTL and testbench

//  Streams a PIXELS-long image from an external synchronous ROM into SDRAM via the FIFO/controller

---
 rtl/sdram_loader_pkg.sv | 27 ++
 rtl/button_edge_sync.sv | 35 +++
 rtl/sdram_image_loader.sv | 147 ++++++++++++++
 tb/tb_sdram_image_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_loader_pkg.sv
// sdram_loader_pkg
//   Shared definitions for the SDRAM image loader:
//     - state_t            : loader FSM state encodings (IDLE..DONE), 3 bits wide
//     - ROM_LAT_MIN/MAX    : supported ROM read-latency range
//     - LAT_CNT_W          : width of the ROM latency counter
//     - rgb332_to_rgb565() : colour expansion by bit replication
package sdram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;
    localparam int LAT_CNT_W   = 3;

    // Replicate the high bits of each channel into the low bits so that full
    // scale maps to full scale (e.g. R3=7 -> R5=31, not 28).
    function automatic logic [15:0] rgb332_to_rgb565(input logic [7:0] d);
        return {d[7:5], d[7:6], d[4:2], d[4:2], d[1:0], d[1:0], d[1]};
    endfunction

endpackage

// File: rtl/button_edge_sync.sv
// button_edge_sync
//   Brings the asynchronous active-low pushbutton into the in_clk domain with
//   a two-flop synchroniser and emits a one-clock pulse on each press
//   (synchronised level going 1 -> 0).
// Ports
//   in_clk     in   system clock
//   in_reset   in   synchronous reset, active-low
//   in_button  in   asynchronous pushbutton, active-low
//   fall_pulse out  one-cycle pulse per button press
module button_edge_sync (
    input  logic in_clk,
    input  logic in_reset,
    input  logic in_button,
    output logic fall_pulse
);

    logic btn_sync_p0;
    logic btn_sync_p1;
    logic btn_prev_p2;

    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            btn_sync_p0 <= 1'b1;
            btn_sync_p1 <= 1'b1;
            btn_prev_p2 <= 1'b1;
        end else begin
            btn_sync_p0 <= in_button;
            btn_sync_p1 <= btn_sync_p0;
            btn_prev_p2 <= btn_sync_p1;
        end
    end

    assign fall_pulse = btn_prev_p2 & ~btn_sync_p1;

endmodule

// File: rtl/sdram_image_loader.sv
// sdram_image_loader
//   Copies a PIXELS-word image from a synchronous ROM into SDRAM through the
//   FIFO/controller write port, one word per accepted handshake, starting at
//   SDRAM word address BASE_ADDR. Optional RGB332 -> RGB565 expansion.
//   A load starts on a button press or, with AUTO_START, once after reset.
// Ports
//   in_clk       in   system clock
//   in_reset     in   synchronous reset, active-low
//   in_button    in   async active-low pushbutton, press = start request
//   rom_addr     out  ROM read address
//   rom_q        in   ROM data, valid ROM_LAT clocks after rom_addr
//   write        out  write request to the SDRAM FIFO
//   write_addr   out  SDRAM word address of the current write
//   writedata    out  SDRAM write data
//   waitrequest  in   1 = write not accepted this cycle
//   busy         out  load in progress
//   done         out  last load completed (sticky until the next start)
//   c_state      out  FSM state (debug)
//   pixel_cnt    out  pixels accepted so far in the current load
module sdram_image_loader
    import sdram_loader_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int ROM_AW     = 19,
    parameter int ROM_DW     = 8,
    parameter int PIXELS     = 76800,
    parameter int BASE_ADDR  = 0,
    parameter int ROM_LAT    = 1,
    parameter int EXPAND     = 0,
    parameter int AUTO_START = 1
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_button,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [ROM_DW-1:0] rom_q,
    output logic              write,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] writedata,
    input  logic              waitrequest,
    output logic              busy,
    output logic              done,
    output logic [2:0]        c_state,
    output logic [ROM_AW-1:0] pixel_cnt
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int LAT = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                         (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;

    state_t                 state;
    state_t                 state_nxt;
    logic                   btn_start;
    logic                   auto_pend;
    logic                   start;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic                   rom_ready;
    logic                   last_pix;
    logic [DATA_W-1:0]      fmt_data;

    button_edge_sync u_btn (
        .in_clk     (in_clk),
        .in_reset   (in_reset),
        .in_button  (in_button),
        .fall_pulse (btn_start)
    );

    // Held high throughout reset, so it reads 1 on exactly the first cycle
    // after release and produces the single automatic start.
    always_ff @(posedge in_clk) begin
        if (!in_reset) auto_pend <= (AUTO_START != 0);
        else           auto_pend <= 1'b0;
    end

    assign start     = btn_start | auto_pend;
    // The address is presented on FETCH entry; the registered ROM output is
    // sampled after LAT further clocks, so FETCH lasts LAT+1 cycles.
    assign rom_ready = (lat_cnt == LAT_CNT_W'(LAT));
    assign last_pix  = ((pixel_cnt + ROM_AW'(1)) == ROM_AW'(PIXELS));

    always_comb begin
        if (EXPAND != 0) fmt_data = DATA_W'(rgb332_to_rgb565(8'(rom_q)));
        else             fmt_data = DATA_W'(rom_q);
    end

    always_ff @(posedge in_clk) begin
        if (!in_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    // Starts are only honoured from IDLE/DONE; a press during a load is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_FETCH;
            ST_FETCH:         if (rom_ready) state_nxt = ST_WRITE;
            ST_WRITE:         if (!waitrequest) state_nxt = ST_NEXT;
            ST_NEXT:          state_nxt = last_pix ? ST_DONE : ST_FETCH;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    assign write   = (state == ST_WRITE);
    assign c_state = state;

    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            rom_addr   <= '0;
            write_addr <= '0;
            writedata  <= '0;
            pixel_cnt  <= '0;
            lat_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_addr   <= '0;
                        write_addr <= ADDR_W'(BASE_ADDR);
                        pixel_cnt  <= '0;
                        lat_cnt    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    lat_cnt <= lat_cnt + LAT_CNT_W'(1);
                    if (rom_ready) writedata <= fmt_data;
                end
                ST_NEXT: begin
                    lat_cnt    <= '0;
                    pixel_cnt  <= pixel_cnt + ROM_AW'(1);
                    rom_addr   <= rom_addr + ROM_AW'(1);
                    write_addr <= write_addr + ADDR_W'(1);
                    if (last_pix) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_image_loader.sv
module tb_sdram_image_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic button;
    logic wr;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] mem [0:255];

    // A: plain copy, latency 1, base 0. B: RGB expansion. C: latency 3, base 100.
    logic [18:0] rom_addr_a, rom_addr_b, rom_addr_c;
    logic [7:0]  rom_q_a, rom_q_b, rom_q_c;
    logic        write_a, write_b, write_c;
    logic [24:0] waddr_a, waddr_b, waddr_c;
    logic [15:0] wdata_a, wdata_b, wdata_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [2:0]  cst_a, cst_b, cst_c;
    logic [18:0] pcnt_a, pcnt_b, pcnt_c;

    logic [40:0] qa[$];
    logic [40:0] qb[$];
    logic [40:0] qc[$];

    always #5 clk = ~clk;

    sdram_image_loader #(.PIXELS(8), .ROM_LAT(1), .BASE_ADDR(0), .EXPAND(0)) u_a (
        .in_clk(clk), .in_reset(rst_n), .in_button(button),
        .rom_addr(rom_addr_a), .rom_q(rom_q_a), .write(write_a), .write_addr(waddr_a),
        .writedata(wdata_a), .waitrequest(wr), .busy(busy_a), .done(done_a),
        .c_state(cst_a), .pixel_cnt(pcnt_a));

    sdram_image_loader #(.PIXELS(8), .ROM_LAT(1), .BASE_ADDR(0), .EXPAND(1)) u_b (
        .in_clk(clk), .in_reset(rst_n), .in_button(button),
        .rom_addr(rom_addr_b), .rom_q(rom_q_b), .write(write_b), .write_addr(waddr_b),
        .writedata(wdata_b), .waitrequest(wr), .busy(busy_b), .done(done_b),
        .c_state(cst_b), .pixel_cnt(pcnt_b));

    sdram_image_loader #(.PIXELS(8), .ROM_LAT(3), .BASE_ADDR(100), .EXPAND(0)) u_c (
        .in_clk(clk), .in_reset(rst_n), .in_button(button),
        .rom_addr(rom_addr_c), .rom_q(rom_q_c), .write(write_c), .write_addr(waddr_c),
        .writedata(wdata_c), .waitrequest(wr), .busy(busy_c), .done(done_c),
        .c_state(cst_c), .pixel_cnt(pcnt_c));

    // Synchronous ROM models: data appears LAT clocks after the address.
    logic [7:0] pc [0:2];
    always @(posedge clk) begin
        rom_q_a <= mem[rom_addr_a[7:0]];
        rom_q_b <= mem[rom_addr_b[7:0]];
        pc[0]   <= mem[rom_addr_c[7:0]];
        pc[1]   <= pc[0];
        pc[2]   <= pc[1];
    end
    assign rom_q_c = pc[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference colour expansion written as channel arithmetic.
    function automatic logic [15:0] ref565(input logic [7:0] b);
        int r, g, bl;
        r  = b / 32;
        g  = (b / 4) % 8;
        bl = b % 4;
        return 16'((r * 4 + r / 2) * 2048 + (g * 9) * 32 + (bl * 8 + bl * 2 + bl / 2));
    endfunction

    function automatic logic [15:0] exp_data(input int id, input int i);
        return (id == 1) ? ref565(mem[i]) : {8'h00, mem[i]};
    endfunction

    function automatic int base_of(input int id);
        return (id == 2) ? 100 : 0;
    endfunction

    task automatic check_load(input string tag, input logic [40:0] q[$], input int id);
        check({tag, "_count"}, 64'(q.size()), 64'd8);
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            check({tag, "_addr"}, 64'(q[i][40:16]), 64'(base_of(id) + i));
            check({tag, "_data"}, 64'(q[i][15:0]), 64'(exp_data(id, i)));
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        mem[3] = 8'hE3;
    endtask

    task automatic clear_queues();
        qa.delete();
        qb.delete();
        qc.delete();
    endtask

    task automatic run_load(input bit stall, input int press_at);
        int cyc;
        cyc = 0;
        while (!(done_a && done_b && done_c) && cyc < 2000) begin
            @(posedge clk); #1;
            wr = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            if (cyc == press_at)     button = 1'b0;
            if (cyc == press_at + 3) button = 1'b1;
            cyc++;
        end
        wr = 1'b0;
        button = 1'b1;
        check("load_timeout", 64'(cyc < 2000), 64'd1);
        @(negedge clk);
    endtask

    task automatic press_button();
        @(posedge clk); #1 button = 1'b0;
        repeat (3) @(posedge clk);
        #1 button = 1'b1;
    endtask

    // Accepted-write capture: write && !waitrequest at the negedge means the
    // coming posedge accepts it.
    always @(negedge clk) begin
        if (rst_n && write_a && !wr) qa.push_back({waddr_a, wdata_a});
        if (rst_n && write_b && !wr) qb.push_back({waddr_b, wdata_b});
        if (rst_n && write_c && !wr) qc.push_back({waddr_c, wdata_c});
    end

    // A stalled write must be held unchanged until accepted.
    logic        stall_prev = 1'b0;
    logic [24:0] stall_addr = '0;
    logic [15:0] stall_data = '0;
    always @(negedge clk) begin
        if (rst_n && stall_prev) begin
            check("stall_write_held", 64'(write_a), 64'd1);
            check("stall_addr", 64'(waddr_a), 64'(stall_addr));
            check("stall_data", 64'(wdata_a), 64'(stall_data));
        end
        if (rst_n) check("write_only_in_write", 64'(write_a), 64'(cst_a == 3'd2));
        stall_prev <= rst_n && write_a && wr;
        stall_addr <= waddr_a;
        stall_data <= wdata_a;
    end

    initial begin
        int cyc;
        rst_n  = 1'b0;
        button = 1'b1;
        wr     = 1'b0;
        randomize_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_write", 64'(write_a), 64'd0);
        check("rst_waddr", 64'(waddr_a), 64'd0);
        check("rst_wdata", 64'(wdata_a), 64'd0);
        check("rst_romaddr", 64'(rom_addr_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_pcnt", 64'(pcnt_a), 64'd0);
        check("rst_state", 64'(cst_a), 64'd0);
        check("rst_waddr_c", 64'(waddr_c), 64'd0);

        // T1/T3/T6: automatic start, no stalls.
        @(posedge clk); #1;
        clear_queues();
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t1_busy", 64'(busy_a), 64'd1);
        check("t1_done_low", 64'(done_a), 64'd0);
        run_load(1'b0, -1);
        check_load("t1_a", qa, 0);
        check_load("t3_b", qb, 1);
        check_load("t6_c", qc, 2);
        check("t3_e3", 64'((qb.size() > 3) ? qb[3][15:0] : 16'h0000), 64'h F81F);
        check("t1_done", 64'(done_a), 64'd1);
        check("t1_busy_end", 64'(busy_a), 64'd0);
        check("t1_pcnt", 64'(pcnt_a), 64'd8);
        check("t1_state", 64'(cst_a), 64'd4);
        check("t1_waddr_end", 64'(waddr_a), 64'd8);
        check("t1_romaddr_end", 64'(rom_addr_a), 64'd8);
        check("t6_waddr_end", 64'(waddr_c), 64'd108);
        check("t6_pcnt", 64'(pcnt_c), 64'd8);
        repeat (10) @(negedge clk);
        check("t1_no_extra", 64'(qa.size()), 64'd8);
        check("t6_no_extra", 64'(qc.size()), 64'd8);

        // T2/T4: restart after done, random stalls, press mid-load ignored.
        randomize_mem();
        clear_queues();
        press_button();
        @(negedge clk);
        check("t4_done_cleared", 64'(done_a), 64'd0);
        check("t4_busy", 64'(busy_a), 64'd1);
        run_load(1'b1, 10);
        check_load("t2_a", qa, 0);
        check_load("t2_b", qb, 1);
        check_load("t2_c", qc, 2);
        repeat (20) @(negedge clk);
        check("t4_still_done", 64'(done_a), 64'd1);
        check("t4_no_queued_a", 64'(qa.size()), 64'd8);
        check("t4_no_queued_c", 64'(qc.size()), 64'd8);

        // T5: reset while a write is stalled.
        randomize_mem();
        wr = 1'b1;
        clear_queues();
        press_button();
        cyc = 0;
        while (!write_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_reach_write", 64'(write_a), 64'd1);
        repeat (2) @(negedge clk);
        check("t5_write_held", 64'(write_a), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("t5_write", 64'(write_a), 64'd0);
        check("t5_waddr", 64'(waddr_a), 64'd0);
        check("t5_wdata", 64'(wdata_a), 64'd0);
        check("t5_romaddr", 64'(rom_addr_a), 64'd0);
        check("t5_busy", 64'(busy_a), 64'd0);
        check("t5_done", 64'(done_a), 64'd0);
        check("t5_pcnt", 64'(pcnt_a), 64'd0);
        check("t5_state", 64'(cst_a), 64'd0);
        check("t5_no_write", 64'(qa.size()), 64'd0);

        // Auto-start after reset reloads from pixel 0.
        wr = 1'b0;
        randomize_mem();
        clear_queues();
        @(posedge clk); #1 rst_n = 1'b1;
        run_load(1'b0, -1);
        check_load("t5r_a", qa, 0);
        check_load("t5r_b", qb, 1);
        check_load("t5r_c", qc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
